// File: rtl/rx_unstrip_ctrl_if.sv
// Lane-side and demux-side signal bundle for rx_unstrip_ctrl.
// The slave modport is the controller; master is whoever feeds lanes and takes bytes.
interface rx_unstrip_ctrl_if;
    logic       lane_vld;
    logic [7:0] FL0;
    logic [7:0] FL1;
    logic [7:0] FL2;
    logic [7:0] FL3;
    logic       lane_pop;
    logic       demux_rdy;
    logic [7:0] to_demux;
    logic       to_demux_vld;
    logic       pkt_start;
    logic       pkt_end;
    logic       pkt_err;
    logic [9:0] pkt_len;
    logic       busy;

    modport master (
        output lane_vld, FL0, FL1, FL2, FL3, demux_rdy,
        input  lane_pop, to_demux, to_demux_vld, pkt_start, pkt_end, pkt_err, pkt_len, busy
    );

    modport slave (
        input  lane_vld, FL0, FL1, FL2, FL3, demux_rdy,
        output lane_pop, to_demux, to_demux_vld, pkt_start, pkt_end, pkt_err, pkt_len, busy
    );
endinterface

// File: rtl/rx_unstrip_ctrl.sv
// Serializes 4-lane symbol columns into a byte stream, framing packets from STP/SDP
// up to END/EDB and flagging nullified or over-length packets.
module rx_unstrip_ctrl #(
    parameter logic [7:0] STP     = 8'hFB,
    parameter logic [7:0] SDP     = 8'h5C,
    parameter logic [7:0] END     = 8'hFD,
    parameter logic [7:0] EDB     = 8'hFE,
    parameter logic [9:0] MAX_LEN = 10'd512
) (
    input  logic               clk,
    input  logic               reset_L,
    rx_unstrip_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_col [4];
    logic [7:0] w_col_nxt [4];
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [9:0] r_len;
    logic [9:0] w_len_nxt;
    logic [9:0] r_pkt_len;
    logic [9:0] w_pkt_len_nxt;
    logic [7:0] r_to_demux;
    logic       r_vld;
    logic       r_start;
    logic       r_end;
    logic       r_busy;

    logic       w_pop;
    logic       w_hs;
    logic       w_term;
    logic       w_ovf;
    logic       w_sof;
    logic [7:0] w_byte;
    logic [7:0] w_byte_nxt;
    logic [9:0] w_len_inc;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        sat_inc = (v == 10'h3FF) ? 10'h3FF : v + 10'd1;
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        is_term = (b == END) || (b == EDB);
    endfunction

    assign w_byte    = r_col[r_ptr];
    assign w_hs      = r_vld & bus.demux_rdy;
    assign w_term    = is_term(w_byte);
    assign w_len_inc = sat_inc(r_len);
    assign w_ovf     = (w_len_inc == MAX_LEN) & ~w_term;
    assign w_sof     = bus.lane_vld & ((bus.FL0 == STP) | (bus.FL0 == SDP));

    // Next-state, column load, pointer and length bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_ptr_nxt     = r_ptr;
        w_len_nxt     = r_len;
        w_pkt_len_nxt = r_pkt_len;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = bus.lane_vld;
                if (w_sof) begin
                    w_col_nxt   = '{bus.FL0, bus.FL1, bus.FL2, bus.FL3};
                    w_ptr_nxt   = 2'd0;
                    w_len_nxt   = 10'd0;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_hs) begin
                    w_len_nxt = w_len_inc;
                    if (w_term) begin
                        w_pkt_len_nxt = w_len_inc;
                        w_state_nxt   = IDLE;
                    end else if (w_ovf) begin
                        w_state_nxt = IDLE;
                    end else if (r_ptr != 2'd3) begin
                        w_ptr_nxt = r_ptr + 2'd1;
                    end else if (bus.lane_vld) begin
                        // Chain straight into the next column so the byte stream has no gap.
                        w_pop     = 1'b1;
                        w_col_nxt = '{bus.FL0, bus.FL1, bus.FL2, bus.FL3};
                        w_ptr_nxt = 2'd0;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            FETCH: begin
                w_pop = bus.lane_vld;
                if (bus.lane_vld) begin
                    w_col_nxt   = '{bus.FL0, bus.FL1, bus.FL2, bus.FL3};
                    w_ptr_nxt   = 2'd0;
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_byte_nxt = w_col_nxt[w_ptr_nxt];

    // State and output registers; outputs are derived from the next state so they
    // line up with the byte being presented.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= IDLE;
            r_col      <= '{default: 8'h00};
            r_ptr      <= 2'd0;
            r_len      <= 10'd0;
            r_pkt_len  <= 10'd0;
            r_to_demux <= 8'h00;
            r_vld      <= 1'b0;
            r_start    <= 1'b0;
            r_end      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_ptr      <= w_ptr_nxt;
            r_len      <= w_len_nxt;
            r_pkt_len  <= w_pkt_len_nxt;
            r_to_demux <= (w_state_nxt == SEND) ? w_byte_nxt : r_to_demux;
            r_vld      <= (w_state_nxt == SEND);
            r_start    <= (w_state_nxt == SEND) && (w_ptr_nxt == 2'd0) && (w_len_nxt == 10'd0);
            r_end      <= (w_state_nxt == SEND) && is_term(w_byte_nxt);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // Error flags the accepting cycle itself, so it coincides with pkt_end on EDB.
    assign bus.pkt_err      = w_hs & ((w_byte == EDB) | w_ovf);
    assign bus.lane_pop     = reset_L & w_pop;
    assign bus.to_demux     = r_to_demux;
    assign bus.to_demux_vld = r_vld;
    assign bus.pkt_start    = r_start;
    assign bus.pkt_end      = r_end;
    assign bus.pkt_len      = r_pkt_len;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_rx_unstrip_ctrl.sv
// Directed bench for rx_unstrip_ctrl: a lane feeder/byte logger plus one task per scenario.
module tb_rx_unstrip_ctrl;

    typedef struct {
        logic [7:0] b;
        logic       s;
        logic       e;
        logic       x;
        int         c;
    } hs_t;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    rx_unstrip_ctrl_if bus();
    rx_unstrip_ctrl_if bus8();

    rx_unstrip_ctrl dut (.clk(clk), .reset_L(reset_L), .bus(bus));
    rx_unstrip_ctrl #(.MAX_LEN(10'd8)) dut8 (.clk(clk), .reset_L(reset_L), .bus(bus8));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int stalls = 0;
    int unstable = 0;
    int err_cycles = 0;
    int err8_cycles = 0;
    int fetch_cycles = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_s = 1'b0;
    logic       prev_e = 1'b0;
    logic [31:0] cq[$];
    logic [31:0] cq8[$];
    hs_t log_q[$];
    hs_t log8_q[$];

    // One clock: drive lanes/ready at negedge, then log what the DUTs present.
    task automatic cycle(input logic rdy, input logic lane_en);
        @(negedge clk);
        bus.demux_rdy  = rdy;
        bus8.demux_rdy = rdy;
        if (lane_en && cq.size() > 0) begin
            bus.lane_vld = 1'b1;
            {bus.FL0, bus.FL1, bus.FL2, bus.FL3} = cq[0];
        end else begin
            bus.lane_vld = 1'b0;
        end
        if (lane_en && cq8.size() > 0) begin
            bus8.lane_vld = 1'b1;
            {bus8.FL0, bus8.FL1, bus8.FL2, bus8.FL3} = cq8[0];
        end else begin
            bus8.lane_vld = 1'b0;
        end
        #1;
        if (prev_stall && (bus.to_demux_vld !== 1'b1 || bus.to_demux !== prev_byte ||
                           bus.pkt_start !== prev_s || bus.pkt_end !== prev_e))
            unstable++;
        prev_stall = bus.to_demux_vld && !rdy;
        if (prev_stall) stalls++;
        prev_byte = bus.to_demux;
        prev_s    = bus.pkt_start;
        prev_e    = bus.pkt_end;
        if (bus.to_demux_vld && rdy)
            log_q.push_back(hs_t'{bus.to_demux, bus.pkt_start, bus.pkt_end, bus.pkt_err, cyc});
        if (bus.pkt_err) err_cycles++;
        if (bus.busy && !bus.to_demux_vld) fetch_cycles++;
        if (bus.lane_pop) begin
            void'(cq.pop_front());
            pops++;
        end
        if (bus8.to_demux_vld && rdy)
            log8_q.push_back(hs_t'{bus8.to_demux, bus8.pkt_start, bus8.pkt_end, bus8.pkt_err, cyc});
        if (bus8.pkt_err) err8_cycles++;
        if (bus8.lane_pop) void'(cq8.pop_front());
        cyc++;
    endtask

    task automatic clear_logs();
        log_q.delete();
        log8_q.delete();
        pops = 0;
        stalls = 0;
        unstable = 0;
        err_cycles = 0;
        err8_cycles = 0;
        fetch_cycles = 0;
        prev_stall = 1'b0;
    endtask

    task automatic test_reset();
        bus.lane_vld = 1'b1;
        {bus.FL0, bus.FL1, bus.FL2, bus.FL3} = 32'hFB010203;
        bus.demux_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.to_demux, bus.to_demux_vld, bus.pkt_start, bus.pkt_end, bus.pkt_err, bus.busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got byte=%h vld=%b s=%b e=%b err=%b busy=%b want all 0",
                     bus.to_demux, bus.to_demux_vld, bus.pkt_start, bus.pkt_end, bus.pkt_err, bus.busy);
        end
        checks++;
        if (bus.pkt_len !== 10'd0) begin
            errors++;
            $display("FAIL reset_pkt_len: got %0d want 0", bus.pkt_len);
        end
        checks++;
        if (bus.lane_pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_lane_pop: got %b want 0", bus.lane_pop);
        end
        bus.lane_vld = 1'b0;
        reset_L = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        checks++;
        if (bus.busy !== 1'b0 || bus.to_demux_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_after: got busy=%b vld=%b want 0 0", bus.busy, bus.to_demux_vld);
        end
    endtask

    task automatic test_basic();
        logic [10:0] exp [7] = '{{8'hFB,3'b100}, {8'h01,3'b000}, {8'h02,3'b000}, {8'h03,3'b000},
                                 {8'h04,3'b000}, {8'h05,3'b000}, {8'hFD,3'b010}};
        int span;
        clear_logs();
        cq = '{32'hFB010203, 32'h040506FD};
        cq[1] = 32'h0405FDF7;
        repeat (12) cycle(1'b1, 1'b1);
        checks++;
        if (log_q.size() != 7) begin
            errors++;
            $display("FAIL basic_count: got %0d want 7", log_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if ({log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h want %h", i,
                             {log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x}, exp[i]);
                end
            end
        end
        span = (log_q.size() == 7) ? log_q[6].c - log_q[0].c : -1;
        checks++;
        if (span != 6) begin
            errors++;
            $display("FAIL basic_consecutive: got span %0d want 6", span);
        end
        checks++;
        if (bus.pkt_len !== 10'd7 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pkt_len: got len=%0d busy=%b want 7 0", bus.pkt_len, bus.busy);
        end
    endtask

    task automatic test_idle_drop();
        logic [10:0] exp [4] = '{{8'h5C,3'b100}, {8'hAA,3'b000}, {8'hBB,3'b000}, {8'hFD,3'b010}};
        clear_logs();
        cq = '{32'h7C7C7C7C, 32'h5CAABBFD};
        repeat (10) cycle(1'b1, 1'b1);
        checks++;
        if (log_q.size() != 4 || pops != 2) begin
            errors++;
            $display("FAIL idle_count: got bytes=%0d pops=%0d want 4 2", log_q.size(), pops);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if ({log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL idle_byte%0d: got %h want %h", i,
                             {log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x}, exp[i]);
                end
            end
        end
        checks++;
        if (bus.pkt_len !== 10'd4) begin
            errors++;
            $display("FAIL idle_pkt_len: got %0d want 4", bus.pkt_len);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp [7] = '{{8'hFB,3'b100}, {8'h01,3'b000}, {8'hFD,3'b010}, {8'h5C,3'b100},
                                 {8'hFB,3'b000}, {8'h03,3'b000}, {8'hFD,3'b010}};
        clear_logs();
        cq = '{32'hFB01FD99, 32'h5CFB03FD};
        repeat (12) cycle(1'b1, 1'b1);
        checks++;
        if (log_q.size() != 7) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 7", log_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if ({log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h want %h", i,
                             {log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x}, exp[i]);
                end
            end
        end
        checks++;
        if (bus.pkt_len !== 10'd4) begin
            errors++;
            $display("FAIL b2b_pkt_len: got %0d want 4", bus.pkt_len);
        end
    endtask

    task automatic test_stall();
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0]  exp [8] = '{8'hFB, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFD};
        clear_logs();
        cq = '{32'hFB112233, 32'h445566FD};
        for (int i = 0; i < 30; i++) cycle(pat[i % 4], 1'b1);
        checks++;
        if (log_q.size() != 8 || stalls == 0 || unstable != 0) begin
            errors++;
            $display("FAIL stall_summary: got bytes=%0d stalls=%0d unstable=%0d want 8 >0 0",
                     log_q.size(), stalls, unstable);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if (log_q[i].b !== exp[i]) begin
                    errors++;
                    $display("FAIL stall_byte%0d: got %h want %h", i, log_q[i].b, exp[i]);
                end
            end
        end
        checks++;
        if (bus.pkt_len !== 10'd8) begin
            errors++;
            $display("FAIL stall_pkt_len: got %0d want 8", bus.pkt_len);
        end
    endtask

    task automatic test_fetch();
        logic [10:0] exp [8] = '{{8'hFB,3'b100}, {8'h01,3'b000}, {8'h02,3'b000}, {8'h03,3'b000},
                                 {8'h04,3'b000}, {8'h05,3'b000}, {8'h06,3'b000}, {8'hFD,3'b010}};
        int gap;
        clear_logs();
        cq = '{32'hFB010203, 32'h040506FD};
        cycle(1'b1, 1'b1);
        repeat (7) cycle(1'b1, 1'b0);
        repeat (8) cycle(1'b1, 1'b1);
        // Three starved cycles plus the cycle that pops the next column.
        checks++;
        if (fetch_cycles != 4) begin
            errors++;
            $display("FAIL fetch_cycles: got %0d want 4", fetch_cycles);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if ({log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL fetch_byte%0d: got %h want %h", i,
                             {log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x}, exp[i]);
                end
            end
        end
        gap = (log_q.size() == 8) ? log_q[4].c - log_q[3].c : -1;
        checks++;
        if (gap != 5) begin
            errors++;
            $display("FAIL fetch_gap: got %0d want 5 (bytes=%0d)", gap, log_q.size());
        end
    endtask

    task automatic test_edb();
        logic [10:0] exp [4] = '{{8'h5C,3'b100}, {8'h01,3'b000}, {8'h02,3'b000}, {8'hFE,3'b011}};
        clear_logs();
        cq = '{32'h5C0102FE};
        repeat (8) cycle(1'b1, 1'b1);
        checks++;
        if (log_q.size() != 4 || err_cycles != 1) begin
            errors++;
            $display("FAIL edb_count: got bytes=%0d err_cycles=%0d want 4 1", log_q.size(), err_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if ({log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL edb_byte%0d: got %h want %h", i,
                             {log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x}, exp[i]);
                end
            end
        end
        checks++;
        if (bus.pkt_len !== 10'd4) begin
            errors++;
            $display("FAIL edb_pkt_len: got %0d want 4", bus.pkt_len);
        end
    endtask

    task automatic test_overflow();
        logic [10:0] exp [8] = '{{8'hFB,3'b100}, {8'h01,3'b000}, {8'h02,3'b000}, {8'h03,3'b000},
                                 {8'h04,3'b000}, {8'h05,3'b000}, {8'h06,3'b000}, {8'h07,3'b001}};
        clear_logs();
        cq8 = '{32'hFBAAFD00};
        repeat (6) cycle(1'b1, 1'b1);
        checks++;
        if (bus8.pkt_len !== 10'd3) begin
            errors++;
            $display("FAIL ovf_pre_len: got %0d want 3", bus8.pkt_len);
        end
        clear_logs();
        cq8 = '{32'hFB010203, 32'h04050607, 32'h08090A0B};
        repeat (20) cycle(1'b1, 1'b1);
        checks++;
        if (log8_q.size() != 8 || err8_cycles != 1) begin
            errors++;
            $display("FAIL ovf_count: got bytes=%0d err_cycles=%0d want 8 1", log8_q.size(), err8_cycles);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log8_q.size()) begin
                checks++;
                if ({log8_q[i].b, log8_q[i].s, log8_q[i].e, log8_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL ovf_byte%0d: got %h want %h", i,
                             {log8_q[i].b, log8_q[i].s, log8_q[i].e, log8_q[i].x}, exp[i]);
                end
            end
        end
        checks++;
        if (bus8.pkt_len !== 10'd3 || bus8.busy !== 1'b0 || bus8.to_demux_vld !== 1'b0 || cq8.size() != 0) begin
            errors++;
            $display("FAIL ovf_after: got len=%0d busy=%b vld=%b left=%0d want 3 0 0 0",
                     bus8.pkt_len, bus8.busy, bus8.to_demux_vld, cq8.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp [4] = '{{8'hFB,3'b100}, {8'hC1,3'b000}, {8'hC2,3'b000}, {8'hFD,3'b010}};
        clear_logs();
        cq = '{32'hFB010203, 32'h040506FD};
        repeat (3) cycle(1'b1, 1'b1);
        @(negedge clk);
        bus.lane_vld = 1'b1;
        {bus.FL0, bus.FL1, bus.FL2, bus.FL3} = 32'hFB000000;
        reset_L = 1'b0;
        #1;
        checks++;
        if ({bus.to_demux, bus.to_demux_vld, bus.pkt_start, bus.pkt_end, bus.pkt_err, bus.busy, bus.lane_pop} !== 14'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got byte=%h vld=%b s=%b e=%b err=%b busy=%b pop=%b want all 0",
                     bus.to_demux, bus.to_demux_vld, bus.pkt_start, bus.pkt_end, bus.pkt_err,
                     bus.busy, bus.lane_pop);
        end
        checks++;
        if (bus.pkt_len !== 10'd0) begin
            errors++;
            $display("FAIL rstmid_pkt_len: got %0d want 0", bus.pkt_len);
        end
        @(posedge clk);
        @(negedge clk);
        bus.lane_vld = 1'b0;
        reset_L = 1'b1;
        clear_logs();
        cq = '{32'h040506FD, 32'hFBC1C2FD};
        repeat (10) cycle(1'b1, 1'b1);
        checks++;
        if (log_q.size() != 4 || err_cycles != 0) begin
            errors++;
            $display("FAIL rstmid_count: got bytes=%0d err_cycles=%0d want 4 0", log_q.size(), err_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                checks++;
                if ({log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x} !== exp[i]) begin
                    errors++;
                    $display("FAIL rstmid_byte%0d: got %h want %h", i,
                             {log_q[i].b, log_q[i].s, log_q[i].e, log_q[i].x}, exp[i]);
                end
            end
        end
        checks++;
        if (bus.pkt_len !== 10'd4) begin
            errors++;
            $display("FAIL rstmid_pkt_len_after: got %0d want 4", bus.pkt_len);
        end
    endtask

    initial begin
        bus.lane_vld   = 1'b0;
        bus.demux_rdy  = 1'b0;
        {bus.FL0, bus.FL1, bus.FL2, bus.FL3} = 32'h0;
        bus8.lane_vld  = 1'b0;
        bus8.demux_rdy = 1'b0;
        {bus8.FL0, bus8.FL1, bus8.FL2, bus8.FL3} = 32'h0;
        test_reset();
        test_basic();
        test_idle_drop();
        test_back_to_back();
        test_stall();
        test_fetch();
        test_edb();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_unstrip_ctrl.md
RX_UNSTRIP_CTRL -- requirements
Module: rx_unstrip_ctrl

Interface
REQ-001 Parameter STP, 8'hFB, start-of-TLP framing symbol.
REQ-002 Parameter SDP, 8'h5C, start-of-DLLP framing symbol.
REQ-003 Parameter END, 8'hFD, good end-of-packet symbol.
REQ-004 Parameter EDB, 8'hFE, nullified end-of-packet symbol.
REQ-005 Parameter MAX_LEN, 10'd512, maximum packet length in bytes, framing symbols included.
REQ-006 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 Port reset_L, input, 1, asynchronous active-low reset.
REQ-008 Port lane_vld, input, 1, one aligned symbol column is present on FL0..FL3.
REQ-009 Ports FL0, FL1, FL2, FL3, input, 8 each, lane 0..3 symbols; FL0 is first in byte order.
REQ-010 Port lane_pop, output, 1, combinational; column consumed this cycle.
REQ-011 Port demux_rdy, input, 1, downstream demux accepts a byte.
REQ-012 Port to_demux, output, 8, registered serialized byte.
REQ-013 Port to_demux_vld, output, 1, to_demux holds a valid byte.
REQ-014 Port pkt_start, output, 1, high with the first byte (STP/SDP) of a packet.
REQ-015 Port pkt_end, output, 1, high with the END or EDB byte.
REQ-016 Port pkt_err, output, 1, one-cycle pulse: EDB termination or length overflow.
REQ-017 Port pkt_len, output, 10, byte count of the last completed packet; holds until next completion.
REQ-018 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-019 States are IDLE, SEND and FETCH, plus 4-entry column register col[0..3], 2-bit pointer ptr and 10-bit counter len.
REQ-020 IDLE: lane_pop=lane_vld; a popped column with FL0 equal to STP or SDP is loaded into col, with ptr=0 and len=0, then the state goes to SEND.
REQ-021 IDLE: any other popped column (PAD, IDL, SKP, data) is discarded; the state stays IDLE.
REQ-022 SEND: to_demux=col[ptr] and to_demux_vld=1; to_demux, to_demux_vld, pkt_start and pkt_end hold stable while demux_rdy=0.
REQ-023 A handshake is to_demux_vld and demux_rdy high in the same cycle; only a handshake advances ptr and increments len.
REQ-024 pkt_start is high exactly while the first byte of a packet is presented (ptr=0, len=0).
REQ-025 Handshake on END: pkt_end=1 with that byte; pkt_len=len+1; remaining column bytes are dropped; next state is IDLE.
REQ-026 Handshake on EDB: same as REQ-025, and pkt_err pulses in the handshake cycle.
REQ-027 Handshake with ptr<3 and no END/EDB: ptr increments and the state stays SEND.
REQ-028 Handshake with ptr=3, no END/EDB and lane_vld=1: lane_pop=1, the new column loads, ptr wraps to 0 and the state stays SEND; there is no bubble.
REQ-029 Handshake with ptr=3, no END/EDB and lane_vld=0: the state goes to FETCH with to_demux_vld=0.
REQ-030 FETCH: lane_pop=lane_vld; the first column popped loads into col with ptr=0, and the state goes to SEND on the next cycle.
REQ-031 lane_pop is never high in SEND except under REQ-028.
REQ-032 A handshake that brings len+1 to MAX_LEN without END/EDB pulses pkt_err, drops to_demux_vld next cycle, leaves pkt_len unchanged, and returns to IDLE.
REQ-033 STP/SDP appearing inside a packet is forwarded as data.
REQ-034 len saturates at 10'h3FF and never wraps.

Reset
REQ-035 reset_L=0 forces immediately: state IDLE, ptr=0, len=0, col=0, to_demux=8'h00, to_demux_vld=0, pkt_start=0, pkt_end=0, pkt_err=0, pkt_len=0, busy=0; lane_pop=0 while reset is asserted.
REQ-036 Reset asserted mid-packet abandons the packet with no pkt_end or pkt_err; after release, the block waits in IDLE for a new STP/SDP.

Verification
REQ-037 Columns {FB,01,02,03} then {04,05,FD,F7}, demux_rdy=1, lane_vld=1 -> bytes FB,01,02,03,04,05,FD on consecutive cycles; pkt_start on FB, pkt_end on FD, pkt_len=7, F7 never output.
REQ-038 Columns {7C,7C,7C,7C} then {5C,AA,BB,FD} -> idle column popped and dropped; output 5C,AA,BB,FD; pkt_len=4.
REQ-039 demux_rdy toggled 1,0,0,1 during a packet -> to_demux stable across stall cycles; no byte duplicated or lost.
REQ-040 lane_vld=0 for 3 cycles after the first column's last byte -> FETCH with to_demux_vld=0; resumes with the next column's FL0.
REQ-041 Packet ending in EDB -> pkt_end and pkt_err high on the same cycle; MAX_LEN=8 with 12 data bytes and no END -> pkt_err after the 8th byte, pkt_len unchanged.
REQ-042 reset_L pulsed low while ptr=2 in SEND -> all outputs 0 asynchronously; a following STP packet is received correctly.
